// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage definitions: exception codes, stall polarity, reset
// polarity and the fetch FSM state encoding.
package if_fetch_stage_pkg;

  localparam int unsigned EXC_CODE_WIDTH = 5;

  localparam logic [EXC_CODE_WIDTH-1:0] EC_None = 5'h1f;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_AdEL = 5'h04;

  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;
  localparam logic RstEnable = 1'b0;

  localparam logic [31:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one bus fetch at a time and
// presents the fetched word (or an address-error exception) to IF/ID.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                stall,
  input  logic                      flush,
  input  logic [31:0]               flush_pc,
  input  logic                      branch_flag,
  input  logic [31:0]               branch_target,
  output logic                      inst_req,
  output logic [31:0]               inst_addr,
  input  logic [31:0]               inst_rdata,
  input  logic                      inst_ready,
  output logic [31:0]               if_pc,
  output logic [31:0]               if_inst,
  output logic [EXC_CODE_WIDTH-1:0] exc_code_o,
  output logic [31:0]               exc_badvaddr_o,
  output logic                      stallreq_if
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_buf_q, inst_buf_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_target_q, pend_target_d;

  logic         misaligned;
  logic         fetch_done;
  logic [31:0]  fetch_word;
  logic [31:0]  next_pc;
  logic         pc_advance;

  // Only the PC-stop bit of the stall vector steers this stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  // Misaligned PCs complete immediately without touching the bus.
  always_comb begin
    misaligned = (pc_q[1:0] != 2'b00);
    fetch_done = (state_q == S_WAIT) && (misaligned || inst_ready);
    fetch_word = misaligned ? ZeroWord : inst_rdata;
    if (flush) begin
      next_pc = flush_pc;
    end else if (branch_flag) begin
      next_pc = branch_target;
    end else if (pend_valid_q) begin
      next_pc = pend_target_q;
    end else begin
      next_pc = pc_q + 32'd4;
    end
  end

  // Bus and pipeline-facing outputs; forced quiet while reset is held.
  always_comb begin
    inst_req       = 1'b0;
    if_inst        = ZeroWord;
    stallreq_if    = 1'b1;
    exc_code_o     = EC_None;
    exc_badvaddr_o = ZeroWord;
    inst_addr      = pc_q;
    if_pc          = pc_q;
    unique case (state_q)
      S_WAIT: begin
        inst_req = !misaligned;
        if (fetch_done) begin
          if_inst     = fetch_word;
          stallreq_if = 1'b0;
        end
      end
      S_HOLD: begin
        if_inst     = inst_buf_q;
        stallreq_if = 1'b0;
      end
      default: ;
    endcase
    if (misaligned) begin
      exc_code_o     = EC_AdEL;
      exc_badvaddr_o = pc_q;
    end
    if (rst == RstEnable) begin
      inst_req       = 1'b0;
      if_inst        = ZeroWord;
      stallreq_if    = 1'b1;
      exc_code_o     = EC_None;
      exc_badvaddr_o = ZeroWord;
    end
  end

  // FSM next state, PC update and pending-branch bookkeeping.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_buf_d    = inst_buf_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pc_advance    = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (fetch_done) begin
          if (stall[0] == NoStop) begin
            pc_advance = 1'b1;
          end else begin
            inst_buf_d = fetch_word;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (stall[0] == NoStop) begin
          pc_advance = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_DROP: begin
        if (inst_ready) begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
    if (pc_advance) begin
      pc_d          = next_pc;
      pend_valid_d  = 1'b0;
      pend_target_d = ZeroWord;
    end else if (branch_flag) begin
      pend_valid_d  = 1'b1;
      pend_target_d = branch_target;
    end
    // Flush wins over everything above: the outstanding fetch (if any) is
    // tracked by S_DROP so its data can be swallowed.
    if (flush) begin
      pc_d          = flush_pc;
      pend_valid_d  = 1'b0;
      pend_target_d = ZeroWord;
      inst_buf_d    = inst_buf_q;
      state_d       = (state_q == S_WAIT && !fetch_done) ? S_DROP : S_WAIT;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q       <= S_WAIT;
      pc_q          <= RESET_PC;
      inst_buf_q    <= ZeroWord;
      pend_valid_q  <= 1'b0;
      pend_target_q <= ZeroWord;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_buf_q    <= inst_buf_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage: owns the PC register and issues one fetch at a time on the instruction bus.
- Presents `if_pc`, `if_inst`, `exc_code_o` and `exc_badvaddr_o` to the IF/ID pipeline register.
- Follows the pipeline controller's `stall[5:0]` and `flush`.
- Raises `stallreq_if` while a fetch is outstanding.
- Applies redirects from the ID-stage branch unit and from the exception unit (`flush_pc`).

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- stall  in  6  pipeline stall vector; bit0 = PC stop, bit1 = IF stop (`Stop`/`NoStop`)
- flush  in  1  exception/ERET flush
- flush_pc  in  32  redirect target on flush
- branch_flag  in  1  ID branch taken
- branch_target  in  32  ID branch target
- inst_req  out  1  fetch request
- inst_addr  out  32  fetch address, equal to pc
- inst_rdata  in  32  returned instruction
- inst_ready  in  1  inst_rdata valid this cycle; completes the request
- if_pc  out  32  PC of the presented instruction
- if_inst  out  32  presented instruction
- exc_code_o  out  `EXC_CODE_WIDTH`  fetch exception code
- exc_badvaddr_o  out  32  faulting address
- stallreq_if  out  1  IF needs the pipeline held

Behaviour:
- Registers:
  - pc (reset RESET_PC)
  - inst_buf (reset 0)
  - pend_valid/pend_target (reset 0/0)
  - state (reset S_WAIT)
- Reset output values: if_pc=RESET_PC, if_inst=0, exc_code_o=`EC_None`, exc_badvaddr_o=0, stallreq_if=1, inst_req=0 while rst low.
- if_pc=pc and inst_addr=pc always.
- Misaligned pc (pc[1:0]!=0):
  - No bus request.
  - Fetch counts as complete in the same cycle with inst=0, exc_code_o=`EC_AdEL`, exc_badvaddr_o=pc.
- Aligned pc: exc_code_o=`EC_None`, exc_badvaddr_o=0.
- next_pc priority: flush→flush_pc; branch_flag→branch_target; pend_valid→pend_target; else pc+4 (wraps mod 2^32).
- States:
  - S_WAIT: inst_req=1 (aligned).
    - Not ready: stallreq_if=1, if_inst=0.
    - inst_ready: if_inst=inst_rdata, stallreq_if=0, pass-through with zero added latency.
      - stall[0]=NoStop → pc<=next_pc, stay in S_WAIT; the next request is issued the following cycle.
      - stall[0]=Stop → inst_buf<=inst_rdata, go to S_HOLD.
  - S_HOLD: inst_req=0, if_inst=inst_buf, stallreq_if=0.
    - When stall[0]=NoStop → pc<=next_pc, go to S_WAIT.
  - S_DROP: fetch killed by flush.
    - inst_req=0, stallreq_if=1, if_inst=0.
    - Returned data is discarded.
    - On inst_ready → go to S_WAIT. pc already holds the flush target.
- Branch arriving while the PC cannot advance (stall[0]=Stop or fetch pending): pend_valid<=1, pend_target<=branch_target. Pend is cleared when pc advances.
- Flush, any state:
  - pc<=flush_pc, pend cleared.
  - S_WAIT with !inst_ready → S_DROP; otherwise → S_WAIT.
  - Flush overrides stall and branch in the same cycle.
- Only one outstanding request at any time; a request is never issued in S_DROP or S_HOLD.
- inst_ready outside S_WAIT/S_DROP is ignored.

Decomposition:
- Shared defines file (existing):
  - `EC_None`, `EC_AdEL`, `EXC_CODE_WIDTH`
  - `Stop`/`NoStop`, `RstEnable`, `ZeroWord`
- Add there: state encodings S_WAIT/S_HOLD/S_DROP (2 bits).
- Single module; no sub-module needed.

Test Plan:
- Reset release, inst_ready=1 every cycle, no stall → inst_addr sequence BFC00000, BFC00004, BFC00008; if_inst tracks rdata; stallreq_if=0 on ready cycles.
- inst_ready delayed 3 cycles at pc=BFC00004 → stallreq_if=1 for 3 cycles, inst_req held, pc unchanged; advances to BFC00008 the cycle after ready.
- Ready at pc=BFC00010 with stall[0]=Stop for 2 cycles → S_HOLD; if_inst=buffered word, inst_req=0; pc advances only after stall releases.
- branch_flag=1, target=BFC00100, while fetch pending → pend latched; after ready pc=BFC00100, not BFC00014.
- flush with flush_pc=BFC00380 while request outstanding → S_DROP; the late rdata=DEADBEEF is never presented; next request address is BFC00380.
- branch_target=BFC00102 → no inst_req; exc_code_o=`EC_AdEL`, exc_badvaddr_o=BFC00102, if_inst=0, stallreq_if=0.
